// File: rtl/register_file.sv
// Architectural register file with per-register rename tags, fed by the ROB
// commit stream and serving operand reads (with bypass) to the instruction unit.
module register_file #(
    parameter int ROB_WIDTH = 4,
    parameter int REG_COUNT = 32
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 clear,
    input  logic                 commitValid,
    input  logic [4:0]           commitDest,
    input  logic [31:0]          commitValue,
    input  logic [ROB_WIDTH-1:0] commitRobId,
    input  logic                 renameValid,
    input  logic [4:0]           renameDest,
    input  logic [ROB_WIDTH-1:0] renameRobId,
    input  logic [4:0]           rs1Index,
    output logic [31:0]          rs1Value,
    output logic                 rs1Busy,
    output logic [ROB_WIDTH-1:0] rs1Dep,
    input  logic [4:0]           rs2Index,
    output logic [31:0]          rs2Value,
    output logic                 rs2Busy,
    output logic [ROB_WIDTH-1:0] rs2Dep
);

    typedef struct packed {
        logic [31:0]          value;
        logic                 busy;
        logic [ROB_WIDTH-1:0] dep;
    } readResult;

    // x0 has no storage; index 0 is never decoded.
    logic [31:0]          regValue [1:REG_COUNT-1];
    logic [ROB_WIDTH-1:0] regTag   [1:REG_COUNT-1];
    logic [REG_COUNT-1:1] regBusy;

    logic [REG_COUNT-1:1] commitSel;
    logic [REG_COUNT-1:1] commitMatch;
    logic [REG_COUNT-1:1] renameSel;

    readResult rs1Result;
    readResult rs2Result;

    // commitMatch marks the register whose pending producer is committing now;
    // it drives both the busy clear and the read bypass.
    always_comb begin
        commitSel   = '0;
        commitMatch = '0;
        renameSel   = '0;
        for (int r = 1; r < REG_COUNT; r++) begin
            commitSel[r]   = commitValid && (commitDest == 5'(r));
            commitMatch[r] = commitSel[r] && regBusy[r] && (regTag[r] == commitRobId);
            renameSel[r]   = renameValid && (renameDest == 5'(r));
        end
    end

    // NOTE: the value array is reset together with busy/tag so that reads during
    // and right after reset return zero; this costs a reset net on every flop.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            regBusy <= '0;
            for (int r = 1; r < REG_COUNT; r++) begin
                regValue[r] <= '0;
                regTag[r]   <= '0;
            end
        end else begin
            for (int r = 1; r < REG_COUNT; r++) begin
                if (commitSel[r]) begin
                    regValue[r] <= commitValue;
                end
                // Priority: flush beats rename, rename beats the commit's busy clear.
                if (clear) begin
                    regBusy[r] <= 1'b0;
                end else if (renameSel[r]) begin
                    regBusy[r] <= 1'b1;
                    regTag[r]  <= renameRobId;
                end else if (commitMatch[r]) begin
                    regBusy[r] <= 1'b0;
                end
            end
        end
    end

    function automatic readResult readPort(input logic [4:0] index);
        readResult res;
        res = '0;
        for (int r = 1; r < REG_COUNT; r++) begin
            if (index == 5'(r)) begin
                res.value = regValue[r];
                res.busy  = regBusy[r];
                res.dep   = regTag[r];
                if (commitMatch[r]) begin
                    res.value = commitValue;
                    res.busy  = 1'b0;
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        rs1Result = readPort(rs1Index);
        rs2Result = readPort(rs2Index);
    end

    assign rs1Value = rs1Result.value;
    assign rs1Busy  = rs1Result.busy;
    assign rs1Dep   = rs1Result.dep;
    assign rs2Value = rs2Result.value;
    assign rs2Busy  = rs2Result.busy;
    assign rs2Dep   = rs2Result.dep;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: rename/commit, bypass, stale
// commits, same-cycle collisions, flush, x0 protection and asynchronous reset.
module tb_register_file;

    localparam int ROB_WIDTH = 4;

    logic                 clockIn = 1'b0;
    logic                 resetIn;
    logic                 clear;
    logic                 commitValid;
    logic [4:0]           commitDest;
    logic [31:0]          commitValue;
    logic [ROB_WIDTH-1:0] commitRobId;
    logic                 renameValid;
    logic [4:0]           renameDest;
    logic [ROB_WIDTH-1:0] renameRobId;
    logic [4:0]           rs1Index;
    logic [31:0]          rs1Value;
    logic                 rs1Busy;
    logic [ROB_WIDTH-1:0] rs1Dep;
    logic [4:0]           rs2Index;
    logic [31:0]          rs2Value;
    logic                 rs2Busy;
    logic [ROB_WIDTH-1:0] rs2Dep;

    int checkCount = 0;
    int errorCount = 0;

    register_file #(.ROB_WIDTH(ROB_WIDTH), .REG_COUNT(32)) dut (
        .clockIn(clockIn), .resetIn(resetIn), .clear(clear),
        .commitValid(commitValid), .commitDest(commitDest),
        .commitValue(commitValue), .commitRobId(commitRobId),
        .renameValid(renameValid), .renameDest(renameDest), .renameRobId(renameRobId),
        .rs1Index(rs1Index), .rs1Value(rs1Value), .rs1Busy(rs1Busy), .rs1Dep(rs1Dep),
        .rs2Index(rs2Index), .rs2Value(rs2Value), .rs2Busy(rs2Busy), .rs2Dep(rs2Dep)
    );

    always #5 clockIn = ~clockIn;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clockIn);
        #1;
    endtask

    task automatic idle();
        clear       = 1'b0;
        commitValid = 1'b0;
        commitDest  = '0;
        commitValue = '0;
        commitRobId = '0;
        renameValid = 1'b0;
        renameDest  = '0;
        renameRobId = '0;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [ROB_WIDTH-1:0] id);
        renameValid = 1'b1;
        renameDest  = rd;
        renameRobId = id;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [ROB_WIDTH-1:0] id, input logic [31:0] v);
        commitValid = 1'b1;
        commitDest  = rd;
        commitRobId = id;
        commitValue = v;
    endtask

    task automatic checkRs1(input string tag, input logic [31:0] v, input logic b, input logic [ROB_WIDTH-1:0] d);
        check({tag, ".value"}, rs1Value, v);
        check({tag, ".busy"}, 32'(rs1Busy), 32'(b));
        if (b) check({tag, ".dep"}, 32'(rs1Dep), 32'(d));
    endtask

    task automatic checkRs2(input string tag, input logic [31:0] v, input logic b, input logic [ROB_WIDTH-1:0] d);
        check({tag, ".value"}, rs2Value, v);
        check({tag, ".busy"}, 32'(rs2Busy), 32'(b));
        if (b) check({tag, ".dep"}, 32'(rs2Dep), 32'(d));
    endtask

    initial begin
        resetIn  = 1'b0;
        idle();
        rs1Index = 5'd5;
        rs2Index = 5'd0;
        #3;
        checkRs1("reset_x5", 32'h0, 1'b0, '0);
        checkRs2("reset_x0", 32'h0, 1'b0, '0);
        @(negedge clockIn);
        resetIn = 1'b1;
        tick();

        // Rename x5 tag 3: same-cycle read still shows the old (idle) state.
        rename(5'd5, 4'd3);
        #1 checkRs1("rename_pre", 32'h0, 1'b0, '0);
        tick();
        idle();
        #1 checkRs1("rename_post", 32'h0, 1'b1, 4'd3);

        // Matching commit bypasses into the read in the same cycle.
        commit(5'd5, 4'd3, 32'hDEADBEEF);
        #1 checkRs1("bypass_x5", 32'hDEADBEEF, 1'b0, '0);
        check("bypass_x5.dep", 32'(rs1Dep), 32'd3);
        tick();
        idle();
        #1 checkRs1("commit_x5", 32'hDEADBEEF, 1'b0, '0);

        // Stale commit: younger rename tag 9 survives commit of tag 2.
        rs2Index = 5'd7;
        rename(5'd7, 4'd2);
        tick();
        rename(5'd7, 4'd9);
        tick();
        idle();
        commit(5'd7, 4'd2, 32'h11);
        #1 checkRs2("stale_nobypass", 32'h0, 1'b1, 4'd9);
        tick();
        idle();
        #1 checkRs2("stale_after", 32'h11, 1'b1, 4'd9);
        commit(5'd7, 4'd9, 32'h22);
        #1 checkRs2("stale_bypass", 32'h22, 1'b0, '0);
        tick();
        idle();
        #1 checkRs2("stale_final", 32'h22, 1'b0, '0);

        // Same-cycle commit and rename of x4: value written, rename wins.
        rs1Index = 5'd4;
        rename(5'd4, 4'd1);
        tick();
        idle();
        commit(5'd4, 4'd1, 32'hAA);
        rename(5'd4, 4'd6);
        #1 checkRs1("collide_bypass", 32'hAA, 1'b0, '0);
        tick();
        idle();
        #1 checkRs1("collide_after", 32'hAA, 1'b1, 4'd6);

        // Flush: drops all busy, ignores rename, still writes the commit value.
        rename(5'd3, 4'd5);
        tick();
        rename(5'd8, 4'd6);
        tick();
        idle();
        rs1Index = 5'd8;
        clear = 1'b1;
        rename(5'd9, 4'd7);
        commit(5'd3, 4'd5, 32'h55);
        #1 checkRs1("clear_read_ignores", 32'h0, 1'b1, 4'd6);
        tick();
        idle();
        rs1Index = 5'd3;
        rs2Index = 5'd8;
        #1 checkRs1("clear_x3", 32'h55, 1'b0, '0);
        checkRs2("clear_x8", 32'h0, 1'b0, '0);
        rs1Index = 5'd9;
        rs2Index = 5'd4;
        #1 checkRs1("clear_x9", 32'h0, 1'b0, '0);
        checkRs2("clear_x4", 32'hAA, 1'b0, '0);

        // x0 is never written and never busy.
        rs1Index = 5'd0;
        commit(5'd0, 4'd4, 32'hFFFF_FFFF);
        rename(5'd0, 4'd4);
        #1 check("x0_same.value", rs1Value, 32'h0);
        check("x0_same.busy", 32'(rs1Busy), 32'h0);
        check("x0_same.dep", 32'(rs1Dep), 32'h0);
        tick();
        idle();
        #1 check("x0_after.value", rs1Value, 32'h0);
        check("x0_after.busy", 32'(rs1Busy), 32'h0);
        check("x0_after.dep", 32'(rs1Dep), 32'h0);

        // Tag at the top of the ROB range, then asynchronous reset mid-cycle.
        rs1Index = 5'd5;
        rs2Index = 5'd7;
        rename(5'd5, 4'd15);
        tick();
        idle();
        #1 checkRs1("tag_max", 32'hDEADBEEF, 1'b1, 4'd15);
        #2 resetIn = 1'b0;
        #1 checkRs1("async_reset_x5", 32'h0, 1'b0, '0);
        check("async_reset_x5.dep", 32'(rs1Dep), 32'h0);
        checkRs2("async_reset_x7", 32'h0, 1'b0, '0);
        commit(5'd7, 4'd0, 32'h77);
        rename(5'd5, 4'd1);
        tick();
        idle();
        #1 checkRs1("reset_held_x5", 32'h0, 1'b0, '0);
        checkRs2("reset_held_x7", 32'h0, 1'b0, '0);
        resetIn = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
